// File: rtl/clause_bank_seq.sv
// Clause store for the SAT engine: streamed load/readback of clause rows plus a
// registered per-cycle evaluation of all live clauses against the variable bus.
module clause_bank_seq #(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_C_LEN = 4,
    parameter int unsigned IDX_W       = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
    parameter int unsigned VIDX_W      = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
    parameter int unsigned CNT_W       = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     load_valid_i,
    output logic                     load_ready_o,
    input  logic [NUM_VARS*2-1:0]    load_clause_i,
    input  logic [WIDTH_C_LEN-1:0]   load_len_i,
    input  logic                     dump_start_i,
    output logic                     dump_valid_o,
    input  logic                     dump_ready_i,
    output logic [NUM_VARS*2-1:0]    dump_clause_o,
    output logic [WIDTH_C_LEN-1:0]   dump_len_o,
    output logic [IDX_W-1:0]         dump_idx_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     full_o,
    input  logic [NUM_VARS*3-1:0]    var_value_i,
    output logic                     eval_valid_o,
    output logic                     all_c_sat_o,
    output logic                     conflict_o,
    output logic [IDX_W-1:0]         conflict_idx_o,
    output logic                     impl_valid_o,
    output logic [IDX_W-1:0]         impl_clause_idx_o,
    output logic [VIDX_W-1:0]        impl_var_idx_o,
    output logic                     impl_value_o
);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic               load_fire;
    logic               last_beat;

    logic [NUM_VARS*2-1:0]  slot_lits [NUM_CLAUSES];
    logic [WIDTH_C_LEN-1:0] slot_len  [NUM_CLAUSES];

    assign full_o       = (count == CNT_W'(NUM_CLAUSES));
    assign load_ready_o = (state == IDLE) && !full_o && !dump_start_i && !clear_i;
    assign load_fire    = load_valid_i && load_ready_o;
    assign last_beat    = ((CNT_W'(ptr) + CNT_W'(1)) == count);
    assign count_o      = count;

    // Readback presents the pointed slot; forced to zero outside a dump
    assign dump_valid_o  = (state == DUMP);
    assign dump_clause_o = dump_valid_o ? slot_lits[ptr] : '0;
    assign dump_len_o    = dump_valid_o ? slot_len[ptr] : '0;
    assign dump_idx_o    = ptr;

    // Next-state: clear overrides everything, loads only happen in IDLE
    always_comb begin
        state_d = state;
        count_d = count;
        ptr_d   = ptr;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
            ptr_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        count_d = count + CNT_W'(1);
                    end else if (dump_start_i && (count != '0)) begin
                        state_d = DUMP;
                        ptr_d   = '0;
                    end
                end
                DUMP: begin
                    if (dump_ready_i) begin
                        if (last_beat) begin
                            state_d = IDLE;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = ptr + IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            ptr   <= ptr_d;
        end
    end

    // Clause storage has no reset; only slots below count are ever observed
    always_ff @(posedge clk) begin
        if (load_fire) begin
            slot_lits[IDX_W'(count)] <= load_clause_i;
            slot_len[IDX_W'(count)]  <= load_len_i;
        end
    end

    logic               all_sat_c, conf_c, impl_c, impl_val_c;
    logic [IDX_W-1:0]   conf_idx_c, impl_cidx_c;
    logic [VIDX_W-1:0]  impl_vidx_c;
    logic               has_true, u_val, pos, neg, vt, vf;
    logic [1:0]         n_un, lit, val;
    logic [VIDX_W-1:0]  u_vidx;
    logic               unused_hi;

    // Per-clause evaluation; unassigned count saturates at 2, encoders keep lowest slot
    always_comb begin
        all_sat_c   = 1'b1;
        conf_c      = 1'b0;
        conf_idx_c  = '0;
        impl_c      = 1'b0;
        impl_cidx_c = '0;
        impl_vidx_c = '0;
        impl_val_c  = 1'b0;
        has_true    = 1'b0;
        n_un        = 2'd0;
        u_vidx      = '0;
        u_val       = 1'b0;
        lit         = 2'd0;
        val         = 2'd0;
        pos         = 1'b0;
        neg         = 1'b0;
        vt          = 1'b0;
        vf          = 1'b0;
        for (int c = 0; c < NUM_CLAUSES; c++) begin
            has_true = 1'b0;
            n_un     = 2'd0;
            u_vidx   = '0;
            u_val    = 1'b0;
            for (int v = 0; v < NUM_VARS; v++) begin
                lit = slot_lits[c][2*v +: 2];
                val = var_value_i[3*v +: 2];
                pos = (lit == 2'b10);
                neg = (lit == 2'b01);
                vt  = (val == 2'b10);
                vf  = (val == 2'b01);
                if ((pos && vt) || (neg && vf)) begin
                    has_true = 1'b1;
                end else if ((pos || neg) && !vt && !vf) begin
                    if (n_un == 2'd0) begin
                        u_vidx = VIDX_W'(v);
                        u_val  = pos;
                    end
                    if (n_un != 2'd2) begin
                        n_un = n_un + 2'd1;
                    end
                end
            end
            if ((CNT_W'(c) < count) && !has_true) begin
                all_sat_c = 1'b0;
                if ((n_un == 2'd0) && !conf_c) begin
                    conf_c     = 1'b1;
                    conf_idx_c = IDX_W'(c);
                end
                if ((n_un == 2'd1) && !impl_c) begin
                    impl_c      = 1'b1;
                    impl_cidx_c = IDX_W'(c);
                    impl_vidx_c = u_vidx;
                    impl_val_c  = u_val;
                end
            end
        end
    end

    // Bit 2 of each variable field carries no meaning here
    always_comb begin
        unused_hi = 1'b0;
        for (int v = 0; v < NUM_VARS; v++) begin
            unused_hi = unused_hi ^ var_value_i[3*v + 2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eval_valid_o      <= 1'b0;
            all_c_sat_o       <= 1'b0;
            conflict_o        <= 1'b0;
            conflict_idx_o    <= '0;
            impl_valid_o      <= 1'b0;
            impl_clause_idx_o <= '0;
            impl_var_idx_o    <= '0;
            impl_value_o      <= 1'b0;
        end else begin
            eval_valid_o      <= (state == IDLE) && !load_fire && !clear_i && !dump_start_i;
            all_c_sat_o       <= all_sat_c;
            conflict_o        <= conf_c;
            conflict_idx_o    <= conf_idx_c;
            impl_valid_o      <= impl_c;
            impl_clause_idx_o <= impl_cidx_c;
            impl_var_idx_o    <= impl_vidx_c;
            impl_value_o      <= impl_val_c;
        end
    end

endmodule

// File: tb/tb_clause_bank_seq.sv
// Scoreboard bench for clause_bank_seq: load/dump streams and clause evaluation
// are compared against bench-held clause lists and an independent evaluator.
module tb_clause_bank_seq;

    localparam int unsigned NC = 5;
    localparam int unsigned NV = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned VW = 3;
    localparam int unsigned CW = 3;

    logic            clk, rst, clear_i;
    logic            load_valid_i, load_ready_o;
    logic [2*NV-1:0] load_clause_i, dump_clause_o;
    logic [LW-1:0]   load_len_i, dump_len_o;
    logic            dump_start_i, dump_valid_o, dump_ready_i;
    logic [IW-1:0]   dump_idx_o, conflict_idx_o, impl_clause_idx_o;
    logic [CW-1:0]   count_o;
    logic            full_o;
    logic [3*NV-1:0] var_value_i;
    logic            eval_valid_o, all_c_sat_o, conflict_o, impl_valid_o, impl_value_o;
    logic [VW-1:0]   impl_var_idx_o;

    clause_bank_seq #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(LW)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
        .load_clause_i(load_clause_i), .load_len_i(load_len_i),
        .dump_start_i(dump_start_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
        .dump_clause_o(dump_clause_o), .dump_len_o(dump_len_o), .dump_idx_o(dump_idx_o),
        .count_o(count_o), .full_o(full_o), .var_value_i(var_value_i),
        .eval_valid_o(eval_valid_o), .all_c_sat_o(all_c_sat_o),
        .conflict_o(conflict_o), .conflict_idx_o(conflict_idx_o),
        .impl_valid_o(impl_valid_o), .impl_clause_idx_o(impl_clause_idx_o),
        .impl_var_idx_o(impl_var_idx_o), .impl_value_o(impl_value_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic sat; logic conf; int cidx; logic impl; int icidx; int ividx; logic ival; } ev_t;
    typedef struct { logic [15:0] cl; logic [3:0] len; int idx; } beat_t;

    localparam logic [15:0] CL_A = 16'h0006;  // x0 | ~x1
    localparam logic [15:0] CL_B = 16'h0020;  // x2
    localparam logic [15:0] CL_C = 16'h0081;  // ~x0 | x3
    localparam logic [15:0] CL_D = 16'hC200;  // x4, x7 field illegal (absent)
    localparam logic [15:0] CL_E = 16'h0000;  // empty clause
    localparam logic [1:0]  VT = 2'b10;
    localparam logic [1:0]  VF = 2'b01;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] model_cl[$];
    logic [3:0]  model_len[$];
    beat_t       dump_q[$];
    ev_t         eval_q[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_one(input logic [15:0] cl, input logic [3:0] len);
        load_valid_i  = 1'b1;
        load_clause_i = cl;
        load_len_i    = len;
        tick();
        model_cl.push_back(cl);
        model_len.push_back(len);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_cl.delete();
        model_len.delete();
    endtask

    function automatic logic [23:0] vset(input logic [23:0] base, input int v, input logic [1:0] code);
        logic [23:0] r;
        r = base;
        r[3*v +: 2] = code;
        return r;
    endfunction

    // Independent clause evaluator over the bench's clause list
    function automatic ev_t model_eval(input logic [23:0] vv);
        ev_t r;
        r = '{sat: 1'b1, conf: 1'b0, cidx: 0, impl: 1'b0, icidx: 0, ividx: 0, ival: 1'b0};
        for (int c = 0; c < model_cl.size(); c++) begin
            int nt = 0;
            int nu = 0;
            int fu = -1;
            logic fpol = 1'b0;
            logic [15:0] cl = model_cl[c];
            for (int v = 0; v < 8; v++) begin
                logic [1:0] lc = cl[2*v +: 2];
                logic [1:0] a  = vv[3*v +: 2];
                logic pol;
                if (lc != 2'b10 && lc != 2'b01) continue;
                pol = (lc == 2'b10);
                if (a == 2'b10 || a == 2'b01) begin
                    if ((a == 2'b10) == pol) nt++;
                end else begin
                    nu++;
                    if (fu < 0) begin fu = v; fpol = pol; end
                end
            end
            if (nt == 0) begin
                r.sat = 1'b0;
                if (nu == 0 && !r.conf) begin r.conf = 1'b1; r.cidx = c; end
                if (nu == 1 && !r.impl) begin r.impl = 1'b1; r.icidx = c; r.ividx = fu; r.ival = fpol; end
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; clear_i = 1'b0; load_valid_i = 1'b0; load_clause_i = '0; load_len_i = '0;
        dump_start_i = 1'b0; dump_ready_i = 1'b0; var_value_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_vec++; if ({full_o, dump_valid_o, eval_valid_o, all_c_sat_o, conflict_o, impl_valid_o} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000", {full_o, dump_valid_o, eval_valid_o, all_c_sat_o, conflict_o, impl_valid_o}); end
        @(negedge clk) rst = 1'b1;
        tick();
        n_vec++; if (load_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", load_ready_o); end
        n_vec++; if (all_c_sat_o !== 1'b1) begin n_err++; $display("FAIL post_reset_allsat got %b want 1", all_c_sat_o); end
        n_vec++; if (eval_valid_o !== 1'b1) begin n_err++; $display("FAIL post_reset_evalvalid got %b want 1", eval_valid_o); end
        model_cl.delete();
        model_len.delete();
    endtask

    task automatic test_load_dump();
        logic [15:0] cls [3];
        logic [3:0]  lns [3];
        int cyc;
        cls = '{CL_A, CL_B, CL_C};
        lns = '{4'd2, 4'd1, 4'd2};
        for (int i = 0; i < 3; i++) begin
            load_valid_i = 1'b1; load_clause_i = cls[i]; load_len_i = lns[i];
            #1;
            n_vec++; if (load_ready_o !== 1'b1) begin n_err++; $display("FAIL load_ready beat %0d got %b want 1", i, load_ready_o); end
            tick();
            model_cl.push_back(cls[i]);
            model_len.push_back(lns[i]);
        end
        load_valid_i = 1'b0;
        #1;
        n_vec++; if (count_o !== CW'(model_cl.size())) begin n_err++; $display("FAIL load_count got %0d want %0d", count_o, model_cl.size()); end
        for (int i = 0; i < model_cl.size(); i++) dump_q.push_back('{cl: model_cl[i], len: model_len[i], idx: i});
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        cyc = 0;
        while (dump_q.size() > 0 && cyc < 40) begin
            dump_ready_i = (cyc % 2 == 0);
            #1;
            n_vec++; if (dump_valid_o !== 1'b1) begin n_err++; $display("FAIL dump_valid cyc %0d got %b want 1", cyc, dump_valid_o); end
            n_vec++; if (dump_idx_o !== IW'(dump_q[0].idx) || dump_clause_o !== dump_q[0].cl || dump_len_o !== dump_q[0].len) begin
                n_err++; $display("FAIL dump_beat cyc %0d got idx %0d cl %h len %0d want idx %0d cl %h len %0d",
                    cyc, dump_idx_o, dump_clause_o, dump_len_o, dump_q[0].idx, dump_q[0].cl, dump_q[0].len); end
            if (dump_ready_i) void'(dump_q.pop_front());
            tick();
            cyc++;
        end
        n_vec++; if (dump_q.size() != 0) begin n_err++; $display("FAIL dump_timeout left %0d want 0", dump_q.size()); dump_q.delete(); end
        dump_ready_i = 1'b0;
        #1;
        n_vec++; if (dump_valid_o !== 1'b0 || load_ready_o !== 1'b1) begin
            n_err++; $display("FAIL dump_end_idle got valid %b ready %b want 0 1", dump_valid_o, load_ready_o); end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 5; i++) load_one(16'h0002 << (2*i), 4'(i));
        load_valid_i = 1'b0;
        #1;
        n_vec++; if (full_o !== 1'b1 || count_o !== 3'd5) begin n_err++; $display("FAIL full got full %b count %0d want 1 5", full_o, count_o); end
        load_valid_i = 1'b1; load_clause_i = 16'hFFFF;
        #1;
        n_vec++; if (load_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", load_ready_o); end
        tick();
        load_valid_i = 1'b0;
        #1;
        n_vec++; if (count_o !== 3'd5) begin n_err++; $display("FAIL sixth_load count got %0d want 5", count_o); end
        clear_i = 1'b1;
        #1;
        n_vec++; if (load_ready_o !== 1'b0) begin n_err++; $display("FAIL clear_ready got %b want 0", load_ready_o); end
        tick();
        clear_i = 1'b0;
        model_cl.delete();
        model_len.delete();
        #1;
        n_vec++; if (count_o !== 3'd0 || full_o !== 1'b0) begin n_err++; $display("FAIL clear_count got %0d full %b want 0 0", count_o, full_o); end
    endtask

    task automatic test_eval();
        logic [23:0] vec [7];
        ev_t e;
        do_clear();
        load_one(CL_A, 4'd2); load_one(CL_B, 4'd1); load_one(CL_C, 4'd2);
        load_valid_i = 1'b0;
        vec[0] = 24'h924924;
        vec[1] = vset(24'h0, 2, VT);
        vec[2] = vset(vset(vec[1], 0, VF), 1, VT);
        vec[3] = vset(vec[2], 3, VF);
        vec[4] = vset(vset(vset(vset(24'h0, 0, VT), 1, VT), 2, VT), 3, VT);
        vec[5] = vec[4];
        vec[6] = 24'h0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin load_one(CL_D, 4'd1); load_one(CL_E, 4'd0); load_valid_i = 1'b0; end
            var_value_i = vec[i];
            eval_q.push_back(model_eval(vec[i]));
            tick();
            e = eval_q.pop_front();
            n_vec++; if (eval_valid_o !== 1'b1 || all_c_sat_o !== e.sat || conflict_o !== e.conf || conflict_idx_o !== IW'(e.cidx)) begin
                n_err++; $display("FAIL eval_conf vec %0d got v%b s%b c%b ci%0d want v1 s%b c%b ci%0d",
                    i, eval_valid_o, all_c_sat_o, conflict_o, conflict_idx_o, e.sat, e.conf, e.cidx); end
            n_vec++; if (impl_valid_o !== e.impl || impl_clause_idx_o !== IW'(e.icidx) || impl_var_idx_o !== VW'(e.ividx) || impl_value_o !== e.ival) begin
                n_err++; $display("FAIL eval_impl vec %0d got u%b ci%0d vi%0d val%b want u%b ci%0d vi%0d val%b",
                    i, impl_valid_o, impl_clause_idx_o, impl_var_idx_o, impl_value_o, e.impl, e.icidx, e.ividx, e.ival); end
            case (i)
                0: begin n_vec++; if ({impl_valid_o, impl_clause_idx_o, impl_var_idx_o, impl_value_o} !== {1'b1, 3'd1, 3'd2, 1'b1}) begin
                       n_err++; $display("FAIL unit_b got %b want 1_001_010_1", {impl_valid_o, impl_clause_idx_o, impl_var_idx_o, impl_value_o}); end end
                1: begin n_vec++; if (all_c_sat_o !== 1'b0 || impl_valid_o !== 1'b0) begin
                       n_err++; $display("FAIL x2_true got sat %b impl %b want 0 0", all_c_sat_o, impl_valid_o); end end
                3: begin n_vec++; if (conflict_o !== 1'b1 || conflict_idx_o !== 3'd0) begin
                       n_err++; $display("FAIL conflict_slot0 got %b idx %0d want 1 0", conflict_o, conflict_idx_o); end end
                4: begin n_vec++; if (all_c_sat_o !== 1'b1 || conflict_o !== 1'b0) begin
                       n_err++; $display("FAIL all_true got sat %b conf %b want 1 0", all_c_sat_o, conflict_o); end end
                5: begin n_vec++; if (conflict_idx_o !== 3'd4 || impl_clause_idx_o !== 3'd3 || impl_var_idx_o !== 3'd4) begin
                       n_err++; $display("FAIL empty_and_unit got ci %0d ui %0d uv %0d want 4 3 4", conflict_idx_o, impl_clause_idx_o, impl_var_idx_o); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_clear_mid_dump();
        do_clear();
        load_one(CL_A, 4'd2); load_one(CL_B, 4'd1); load_one(CL_C, 4'd2);
        load_valid_i = 1'b0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        dump_ready_i = 1'b1;
        tick();
        dump_ready_i = 1'b0;
        load_valid_i = 1'b1;
        #1;
        n_vec++; if (dump_valid_o !== 1'b1 || dump_idx_o !== 3'd1 || dump_clause_o !== CL_B) begin
            n_err++; $display("FAIL mid_dump got v%b idx %0d cl %h want 1 1 %h", dump_valid_o, dump_idx_o, dump_clause_o, CL_B); end
        n_vec++; if (load_ready_o !== 1'b0) begin n_err++; $display("FAIL dump_load_stall got %b want 0", load_ready_o); end
        load_valid_i = 1'b0;
        do_clear();
        #1;
        n_vec++; if (dump_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++; $display("FAIL clear_dump got v%b count %0d want 0 0", dump_valid_o, count_o); end
        dump_start_i = 1'b1;
        dump_ready_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (dump_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_dump cyc %0d got %b want 0", i, dump_valid_o); end
            tick();
        end
        dump_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        load_one(CL_A, 4'd2); load_one(CL_B, 4'd1); load_one(CL_C, 4'd2);
        load_valid_i = 1'b0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_vec++; if ({dump_valid_o, dump_clause_o, dump_len_o, dump_idx_o, count_o, full_o} !== '0) begin
            n_err++; $display("FAIL async_dump got v%b cl %h len %0d idx %0d cnt %0d full %b want all 0",
                dump_valid_o, dump_clause_o, dump_len_o, dump_idx_o, count_o, full_o); end
        n_vec++; if ({eval_valid_o, all_c_sat_o, conflict_o, conflict_idx_o, impl_valid_o, impl_clause_idx_o, impl_var_idx_o, impl_value_o} !== '0) begin
            n_err++; $display("FAIL async_eval got %b want all 0",
                {eval_valid_o, all_c_sat_o, conflict_o, conflict_idx_o, impl_valid_o, impl_clause_idx_o, impl_var_idx_o, impl_value_o}); end
        model_cl.delete();
        model_len.delete();
        @(negedge clk) rst = 1'b1;
        tick();
        n_vec++; if (load_ready_o !== 1'b1 || all_c_sat_o !== 1'b1 || count_o !== 3'd0) begin
            n_err++; $display("FAIL after_reset got ready %b sat %b count %0d want 1 1 0", load_ready_o, all_c_sat_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_load_dump();
        test_full();
        test_eval();
        test_clear_mid_dump();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
